// File: rtl/ff_bank.sv
// ff_bank: a bank of WIDTH independent flip-flop channels that share one
// mode select (SR / JK / D / T), plus a sticky flag for illegal SR events.
// Optional feature: define FF_BANK_ERRCNT_EN to add the saturating
// illegal-event counter and its err_cnt port. Without the macro, the port
// and the counter logic are both absent, and err behaves the same.

// One channel: next-state selection and the state register.
module ff_lane #(
   parameter int BOTH_POLICY = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] mode,
   input  logic       a,
   input  logic       b,
   output logic       q
);

   localparam logic [1:0] MODE_SR = 2'b00;
   localparam logic [1:0] MODE_JK = 2'b01;
   localparam logic [1:0] MODE_D  = 2'b10;

   logic nxt;

   // next state for this channel in the current mode
   always_comb begin
      nxt = q;
      unique case (mode)
         MODE_SR: begin
            unique case ({a, b})
               2'b10:   nxt = 1'b1;
               2'b01:   nxt = 1'b0;
               2'b11: begin
                  // s=r=1: the policy picks set, reset, or hold (default)
                  if (BOTH_POLICY == 1)      nxt = 1'b1;
                  else if (BOTH_POLICY == 2) nxt = 1'b0;
                  else                       nxt = q;
               end
               default: nxt = q;
            endcase
         end
         MODE_JK: begin
            unique case ({a, b})
               2'b10:   nxt = 1'b1;
               2'b01:   nxt = 1'b0;
               2'b11:   nxt = ~q;
               default: nxt = q;
            endcase
         end
         MODE_D:  nxt = a;
         default: nxt = a ? ~q : q;   // T
      endcase
   end

   // state register: sync active-low reset, en gates the update
   always_ff @(posedge clk) begin
      if (!rst)
         q <= 1'b0;
      else if (en)
         q <= nxt;
   end

endmodule

module ff_bank #(
   parameter int WIDTH       = 4,
   parameter int BOTH_POLICY = 0,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             clr_err,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn,
   output logic             err
`ifdef FF_BANK_ERRCNT_EN
   ,
   output logic [CNT_W-1:0] err_cnt
`endif
);

   // an illegal event is one SR cycle with s=r=1 on any channel; it counts
   // once per cycle no matter how many channels hit it
   logic illegal;
   assign illegal = en && (mode == 2'b00) && (|(a & b));

   assign qn = ~q;

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      ff_lane #(
         .BOTH_POLICY (BOTH_POLICY)
      ) u_lane (
         .clk  (clk),
         .rst  (rst),
         .en   (en),
         .mode (mode),
         .a    (a[i]),
         .b    (b[i]),
         .q    (q[i])
      );
   end

   // sticky error flag; clear wins over a same-cycle event and ignores en
   always_ff @(posedge clk) begin
      if (!rst)
         err <= 1'b0;
      else if (clr_err)
         err <= 1'b0;
      else if (illegal)
         err <= 1'b1;
   end

`ifdef FF_BANK_ERRCNT_EN
   // saturating event counter, cleared together with err
   always_ff @(posedge clk) begin
      if (!rst)
         err_cnt <= '0;
      else if (clr_err)
         err_cnt <= '0;
      else if (illegal && (err_cnt != {CNT_W{1'b1}}))
         err_cnt <= err_cnt + 1'b1;
   end
`endif

endmodule
